// File: rtl/vu_frame_ctrl.sv
// vu_frame_ctrl: once per frame, samples one audio level during vertical
// blanking, updates a decaying level bar and a held peak marker, and renders
// the bar as registered 3-3-2 RGB pixels during the active area.
module vu_frame_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int BAR_Y0     = 200,
    parameter int BAR_H      = 80,
    parameter int SEG_SHIFT  = 2,
    parameter int YEL_TH     = 100,
    parameter int RED_TH     = 140,
    parameter int DECAY      = 2,
    parameter int PEAK_HOLD  = 30,
    parameter int SAMPLE_WIN = 1024
) (
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       video_on,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic [7:0] level_in,
    input  logic       level_valid,
    output logic       level_ready,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue
);

    typedef enum logic [1:0] {
        DISPLAY = 2'd0,
        SAMPLE  = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    localparam int WIN_W  = (SAMPLE_WIN > 1) ? $clog2(SAMPLE_WIN) : 1;
    localparam int HOLD_W = (PEAK_HOLD > 0) ? $clog2(PEAK_HOLD + 1) : 1;

    localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(SAMPLE_WIN - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(PEAK_HOLD);
    localparam logic [7:0]        DECAY_STEP = 8'(DECAY);
    localparam logic [10:0]       H_END      = 11'(H_ACTIVE);
    localparam logic [10:0]       ROW_FIRST  = 11'(BAR_Y0);
    localparam logic [10:0]       ROW_END    = 11'(BAR_Y0 + BAR_H);
    localparam logic [9:0]        SEG_YEL    = 10'(YEL_TH);
    localparam logic [9:0]        SEG_RED    = 10'(RED_TH);

    // Packed {red, green, blue} colour codes.
    localparam logic [7:0] RGB_BLACK  = 8'b000_000_00;
    localparam logic [7:0] RGB_GREEN  = 8'b000_111_00;
    localparam logic [7:0] RGB_YELLOW = 8'b111_111_00;
    localparam logic [7:0] RGB_RED    = 8'b111_000_00;
    localparam logic [7:0] RGB_WHITE  = 8'b111_111_11;

    state_t              state;
    state_t              state_next;
    logic [WIN_W-1:0]    win_cnt;
    logic [7:0]          cap;
    logic [7:0]          disp;
    logic [7:0]          peak;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                handshake;
    logic                timeout;
    logic [7:0]          disp_dec;
    logic [7:0]          disp_next;
    logic [7:0]          peak_next;
    logic [HOLD_W-1:0]   hold_next;

    logic [9:0]          seg;
    logic                in_bar;
    logic                in_cols;
    logic                is_lit;
    logic                is_peak;
    logic [7:0]          pix_rgb;

    // A sample is taken on valid, or abandoned once the window's last cycle passes.
    assign handshake = level_ready && level_valid;
    assign timeout   = level_ready && (win_cnt == WIN_LAST);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) state <= DISPLAY;
        else       state <= state_next;
    end

    // Next-state logic; frame_start only matters while displaying.
    // NOTE: defaults at the top of a combinational block keep it from inferring latches.
    always_comb begin
        state_next = state;
        case (state)
            DISPLAY: if (frame_start)           state_next = SAMPLE;
            SAMPLE:  if (handshake || timeout)  state_next = UPDATE;
            UPDATE:                             state_next = DISPLAY;
            default:                            state_next = DISPLAY;
        endcase
    end

    // FSM outputs decode straight from state, so reset drops level_ready at once.
    always_comb begin
        level_ready = (state == SAMPLE);
    end

    // Sample window counter and captured level; a handshake beats a timeout.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            win_cnt <= '0;
            cap     <= '0;
        end else begin
            case (state)
                DISPLAY: if (frame_start) win_cnt <= '0;
                SAMPLE: begin
                    if (handshake)    cap     <= level_in;
                    else if (timeout) cap     <= '0;
                    else              win_cnt <= win_cnt + WIN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Bar and peak arithmetic evaluated from the captured level.
    always_comb begin
        disp_dec  = (disp > DECAY_STEP) ? (disp - DECAY_STEP) : 8'd0;
        disp_next = (cap >= disp) ? cap : ((disp_dec > cap) ? disp_dec : cap);
        peak_next = peak;
        hold_next = hold_cnt;
        if (cap >= peak) begin
            peak_next = cap;
            hold_next = HOLD_INIT;
        end else if (hold_cnt != '0) begin
            hold_next = hold_cnt - HOLD_W'(1);
        end else begin
            // cap < peak here, so peak is at least 1 and cannot wrap.
            peak_next = ((peak - 8'd1) > disp_next) ? (peak - 8'd1) : disp_next;
        end
    end

    // Bar state moves only in UPDATE, so a visible frame never tears.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            disp     <= '0;
            peak     <= '0;
            hold_cnt <= '0;
        end else if (state == UPDATE) begin
            disp     <= disp_next;
            peak     <= peak_next;
            hold_cnt <= hold_next;
        end
    end

    assign seg     = h_count >> SEG_SHIFT;
    assign in_bar  = ({1'b0, v_count} >= ROW_FIRST) && ({1'b0, v_count} < ROW_END);
    assign in_cols = ({1'b0, h_count} < H_END);
    assign is_lit  = seg < {2'b00, disp};
    assign is_peak = (peak != 8'd0) && (seg == {2'b00, peak - 8'd1});

    // Pixel colour: peak marker over lit bar, bar colour by segment band.
    always_comb begin
        pix_rgb = RGB_BLACK;
        if (video_on && in_bar && in_cols) begin
            if (is_peak)              pix_rgb = RGB_WHITE;
            else if (is_lit) begin
                if (seg < SEG_YEL)      pix_rgb = RGB_GREEN;
                else if (seg < SEG_RED) pix_rgb = RGB_YELLOW;
                else                    pix_rgb = RGB_RED;
            end
        end
    end

    // Registered colour outputs, one cycle behind the pixel coordinates.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) {red, green, blue} <= RGB_BLACK;
        else       {red, green, blue} <= pix_rgb;
    end

endmodule

// File: tb/tb_vu_frame_ctrl.sv
// tb_vu_frame_ctrl: directed bench for vu_frame_ctrl with a render vector
// table and hand-written frame sequences for sampling, decay, timeout and reset.
module tb_vu_frame_ctrl;

    logic       pixel_clock = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       video_on;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic [7:0] level_in;
    logic       level_valid;
    logic       level_ready;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;

    vu_frame_ctrl dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .frame_start (frame_start),
        .video_on    (video_on),
        .h_count     (h_count),
        .v_count     (v_count),
        .level_in    (level_in),
        .level_valid (level_valid),
        .level_ready (level_ready),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    always #5 pixel_clock = ~pixel_clock;

    localparam logic [7:0] BLK = 8'h00;
    localparam logic [7:0] GRN = 8'h1C;
    localparam logic [7:0] YEL = 8'hFC;
    localparam logic [7:0] RED = 8'hE0;
    localparam logic [7:0] WHT = 8'hFF;

    typedef struct {
        int         phase;
        int         v;
        int         h;
        bit         on;
        logic [7:0] rgb;
    } pix_vec_t;

    localparam int NV = 29;
    pix_vec_t vecs [NV];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick;
        @(negedge pixel_clock);
    endtask

    // One frame with the sample offered on the first SAMPLE cycle.
    task automatic frame_hs(input logic [7:0] lvl);
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        level_valid = 1'b1;
        level_in    = lvl;
        tick;
        level_valid = 1'b0;
        tick;
    endtask

    // One frame with no sample; counts cycles level_ready is seen high and
    // pulses frame_start once mid-window, which must not restart the window.
    task automatic frame_timeout(output int hi, input int fs_at);
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        hi = 0;
        while (level_ready === 1'b1 && hi < 2000) begin
            hi++;
            if (hi == fs_at) frame_start = 1'b1;
            tick;
            frame_start = 1'b0;
        end
        tick;
    endtask

    // Apply every render vector of a phase; colour must lag coordinates by one cycle.
    task automatic render_phase(input int ph);
        logic [7:0] prev;
        video_on = 1'b0;
        h_count  = '0;
        v_count  = '0;
        tick;
        check($sformatf("blank_p%0d", ph), {red, green, blue}, BLK);
        prev = BLK;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].phase == ph) begin
                v_count  = 10'(vecs[i].v);
                h_count  = 10'(vecs[i].h);
                video_on = vecs[i].on;
                #1;
                check($sformatf("latency_p%0d_v%0d", ph, i), {red, green, blue}, prev);
                tick;
                check($sformatf("pixel_p%0d_v%0d", ph, i), {red, green, blue}, vecs[i].rgb);
                prev = vecs[i].rgb;
            end
        end
        video_on = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int exp_disp;
        int exp_peak;
        int exp_hold;

        // phase 0: disp=0 peak=0
        vecs[0]  = '{0, 210, 200, 1'b1, BLK};
        vecs[1]  = '{0, 210,   0, 1'b1, BLK};
        vecs[2]  = '{0, 210, 596, 1'b1, BLK};
        // phase 1: disp=255 peak=255
        vecs[3]  = '{1, 210, 636, 1'b1, RED};
        vecs[4]  = '{1, 210, 639, 1'b1, RED};
        vecs[5]  = '{1, 210, 640, 1'b1, BLK};
        vecs[6]  = '{1, 210, 1019, 1'b1, BLK};
        vecs[7]  = '{1, 210, 200, 1'b1, GRN};
        vecs[8]  = '{1, 210, 420, 1'b1, YEL};
        vecs[9]  = '{1, 210, 636, 1'b0, BLK};
        vecs[10] = '{1, 199, 636, 1'b1, BLK};
        // phase 2: disp=150 peak=150
        vecs[11] = '{2, 210, 580, 1'b1, RED};
        vecs[12] = '{2, 210, 556, 1'b1, YEL};
        vecs[13] = '{2, 210, 560, 1'b1, RED};
        vecs[14] = '{2, 210, 596, 1'b1, WHT};
        vecs[15] = '{2, 210, 600, 1'b1, BLK};
        vecs[16] = '{2, 210, 396, 1'b1, GRN};
        vecs[17] = '{2, 210, 400, 1'b1, YEL};
        // phase 3: disp=120 peak=150
        vecs[18] = '{3, 210, 200, 1'b1, GRN};
        vecs[19] = '{3, 210, 440, 1'b1, YEL};
        vecs[20] = '{3, 210, 596, 1'b1, WHT};
        vecs[21] = '{3, 210, 476, 1'b1, YEL};
        vecs[22] = '{3, 210, 480, 1'b1, BLK};
        vecs[23] = '{3, 199, 200, 1'b1, BLK};
        vecs[24] = '{3, 210, 200, 1'b0, BLK};
        vecs[25] = '{3, 279, 200, 1'b1, GRN};
        vecs[26] = '{3, 280, 200, 1'b1, BLK};
        vecs[27] = '{3, 200,   0, 1'b1, GRN};
        vecs[28] = '{3, 210, 599, 1'b1, WHT};

        reset       = 1'b1;
        frame_start = 1'b0;
        video_on    = 1'b0;
        h_count     = '0;
        v_count     = '0;
        level_in    = '0;
        level_valid = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        tick;

        check("rst_ready", level_ready, 0);
        check("rst_rgb",   {red, green, blue}, BLK);
        check("rst_disp",  dut.disp, 0);
        check("rst_peak",  dut.peak, 0);
        check("rst_hold",  dut.hold_cnt, 0);
        check("rst_cap",   dut.cap, 0);
        check("rst_win",   dut.win_cnt, 0);

        // First sample: level 50 offered the cycle after frame_start.
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        check("s1_ready_in_sample", level_ready, 1);
        level_valid = 1'b1;
        level_in    = 8'd50;
        tick;
        level_valid = 1'b0;
        check("s1_ready_in_update", level_ready, 0);
        check("s1_cap", dut.cap, 50);
        check("s1_disp_before_update", dut.disp, 0);
        tick;
        check("s1_disp", dut.disp, 50);
        check("s1_peak", dut.peak, 50);
        check("s1_hold", dut.hold_cnt, 30);
        check("s1_ready_display", level_ready, 0);

        // Decay toward 10 with peak hold, then peak fall bounded by disp.
        for (int k = 1; k <= 45; k++) begin
            frame_hs(8'd10);
            exp_disp = (50 - 2 * k > 10) ? 50 - 2 * k : 10;
            if (k <= 30) begin
                exp_peak = 50;
                exp_hold = 30 - k;
            end else begin
                exp_hold = 0;
                exp_peak = (50 - (k - 30) > exp_disp) ? 50 - (k - 30) : exp_disp;
            end
            check($sformatf("decay_disp_f%0d", k), dut.disp, exp_disp);
            check($sformatf("decay_peak_f%0d", k), dut.peak, exp_peak);
            check($sformatf("decay_hold_f%0d", k), dut.hold_cnt, exp_hold);
        end

        // Timeout: no valid for the whole window.
        frame_timeout(hi, 300);
        check("to_window_cycles", hi, 1024);
        check("to_cap",   dut.cap, 0);
        check("to_disp",  dut.disp, 8);
        check("to_peak",  dut.peak, 34);
        check("to_hold",  dut.hold_cnt, 0);
        check("to_ready", level_ready, 0);

        // Handshake on the very last window cycle wins over the timeout.
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        repeat (1023) tick;
        check("last_cycle_ready", level_ready, 1);
        level_valid = 1'b1;
        level_in    = 8'd200;
        tick;
        level_valid = 1'b0;
        check("last_cycle_cap", dut.cap, 200);
        check("last_cycle_update", level_ready, 0);
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        check("last_cycle_disp", dut.disp, 200);
        check("last_cycle_peak", dut.peak, 200);
        check("last_cycle_hold", dut.hold_cnt, 30);
        tick;
        check("fs_in_update_ignored", level_ready, 0);
        tick;
        check("fs_in_update_ignored2", level_ready, 0);

        // Reset in the middle of SAMPLE with a sample on offer.
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        check("mid_sample_ready", level_ready, 1);
        level_valid = 1'b1;
        level_in    = 8'd77;
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_ready", level_ready, 0);
        check("async_rst_disp",  dut.disp, 0);
        check("async_rst_peak",  dut.peak, 0);
        check("async_rst_hold",  dut.hold_cnt, 0);
        check("async_rst_cap",   dut.cap, 0);
        check("async_rst_win",   dut.win_cnt, 0);
        tick;
        tick;
        reset = 1'b0;
        repeat (3) tick;
        check("post_rst_wait_ready", level_ready, 0);
        check("post_rst_no_cap",     dut.cap, 0);
        check("post_rst_disp",       dut.disp, 0);
        level_valid = 1'b0;

        render_phase(0);

        frame_hs(8'd255);
        check("full_disp", dut.disp, 255);
        check("full_peak", dut.peak, 255);
        render_phase(1);

        reset = 1'b1;
        tick;
        reset = 1'b0;
        tick;
        frame_hs(8'd150);
        check("p150_disp", dut.disp, 150);
        check("p150_peak", dut.peak, 150);
        render_phase(2);

        repeat (15) frame_hs(8'd120);
        check("p120_disp", dut.disp, 120);
        check("p120_peak", dut.peak, 150);
        check("p120_hold", dut.hold_cnt, 15);
        render_phase(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
